quote_order_gen: RTL and testbench

Downstream stage of the trading logic: takes each per-stock buy/sell quote pair it produces, queues the pair, and serialises it into individual order messages on a valid/ready stream toward the order-entry encoder. With deduplication built in, it also suppresses quote sides whose price matches the last one sent for that stock. It absorbs back-pressure from the encoder through an internal FIFO and counts quotes dropped on overflow.

---
 rtl/trading_pkg.sv | 29 ++
 rtl/quote_fifo.sv | 43 ++++
 rtl/quote_order_gen.sv | 164 ++++++++++++++++
 tb/tb_quote_order_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trading_pkg.sv
// Shared types for the quote-to-order path: order sides, serialiser states
// and the queued quote entry layout.
package trading_pkg;

    localparam int DROP_CNT_WIDTH = 16;
    localparam int QUOTE_PRICE_W  = 32;
    localparam int QUOTE_STOCK_W  = 2;

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } order_side_e;

    // Field order is the same as the FIFO word packed by quote_order_gen.
    typedef struct packed {
        logic [QUOTE_STOCK_W-1:0] stock;
        logic [QUOTE_PRICE_W-1:0] buy;
        logic [QUOTE_PRICE_W-1:0] sell;
        logic                     buy_en;
        logic                     sell_en;
    } quote_entry_t;

    typedef enum logic [1:0] {
        SER_IDLE      = 2'd0,
        SER_SEND_BUY  = 2'd1,
        SER_SEND_SELL = 2'd2
    } ser_state_e;

endpackage

// File: rtl/quote_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two.
module quote_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/quote_order_gen.sv
// Queues buy/sell quote pairs and serialises them into single-side orders on a
// valid/ready stream. Define QUOTE_DEDUP_EN to suppress sides whose price repeats.
module quote_order_gen
    import trading_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STOCKS = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int SEQ_WIDTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_data_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic [DATA_WIDTH-1:0]         i_buy_price,
    input  logic [DATA_WIDTH-1:0]         i_sell_price,
    output logic                          o_order_valid,
    input  logic                          i_order_ready,
    output logic                          o_order_side,
    output logic [$clog2(NUM_STOCKS)-1:0] o_order_stock_id,
    output logic [DATA_WIDTH-1:0]         o_order_price,
    output logic [SEQ_WIDTH-1:0]          o_order_seq,
    output logic [DROP_CNT_WIDTH-1:0]     o_drop_count
);

    localparam int ID_W    = $clog2(NUM_STOCKS);
    localparam int ENTRY_W = ID_W + 2 * DATA_WIDTH + 2;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // ---- Stage 1: input register and side mask ----
    logic                  vld_p1;
    logic [ID_W-1:0]       stock_p1;
    logic [DATA_WIDTH-1:0] buy_p1, sell_p1;
    logic                  buy_en_p1, sell_en_p1;
    logic                  push_req_p1, push_ok_p1;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0]    fifo_rd;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_p1   <= 1'b0;
            stock_p1 <= '0;
            buy_p1   <= '0;
            sell_p1  <= '0;
        end else begin
            vld_p1 <= i_data_valid;
            if (i_data_valid) begin
                stock_p1 <= i_stock_id;
                buy_p1   <= i_buy_price;
                sell_p1  <= i_sell_price;
            end
        end
    end

`ifdef QUOTE_DEDUP_EN
    logic [DATA_WIDTH-1:0] tbl_buy  [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] tbl_sell [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] tbl_vld;

    assign buy_en_p1  = !tbl_vld[stock_p1] || (tbl_buy[stock_p1]  != buy_p1);
    assign sell_en_p1 = !tbl_vld[stock_p1] || (tbl_sell[stock_p1] != sell_p1);

    // Table only learns from quotes that actually entered the FIFO.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)         tbl_vld <= '0;
        else if (push_ok_p1) tbl_vld[stock_p1] <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (push_ok_p1) begin
            if (buy_en_p1)  tbl_buy[stock_p1]  <= buy_p1;
            if (sell_en_p1) tbl_sell[stock_p1] <= sell_p1;
        end
    end
`else
    assign buy_en_p1  = 1'b1;
    assign sell_en_p1 = 1'b1;
`endif

    assign push_req_p1 = vld_p1 && (buy_en_p1 || sell_en_p1);
    assign push_ok_p1  = push_req_p1 && !fifo_full;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                       o_drop_count <= '0;
        else if (push_req_p1 && fifo_full) o_drop_count <= sat_inc(o_drop_count);
    end

    quote_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_reset),
        .push    (push_ok_p1),
        .wr_data ({stock_p1, buy_p1, sell_p1, buy_en_p1, sell_en_p1}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---- Stage 2: serialiser hold register and FSM ----
    logic [ID_W-1:0]       head_stock;
    logic [DATA_WIDTH-1:0] head_buy, head_sell;
    logic                  head_buy_en, head_sell_en;
    logic [ID_W-1:0]       stock_p2;
    logic [DATA_WIDTH-1:0] buy_p2, sell_p2;
    logic                  sell_en_p2;
    ser_state_e            state, state_nxt;
    logic                  xfer;

    assign {head_stock, head_buy, head_sell, head_buy_en, head_sell_en} = fifo_rd;

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = head_buy_en ? SER_SEND_BUY : SER_SEND_SELL;
                end
            end
            SER_SEND_BUY: begin
                if (i_order_ready) state_nxt = sell_en_p2 ? SER_SEND_SELL : SER_IDLE;
            end
            SER_SEND_SELL: begin
                if (i_order_ready) state_nxt = SER_IDLE;
            end
            default: state_nxt = SER_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= SER_IDLE;
            stock_p2    <= '0;
            buy_p2      <= '0;
            sell_p2     <= '0;
            sell_en_p2  <= 1'b0;
            o_order_seq <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_pop) begin
                stock_p2   <= head_stock;
                buy_p2     <= head_buy;
                sell_p2    <= head_sell;
                sell_en_p2 <= head_sell_en;
            end
            if (xfer) o_order_seq <= o_order_seq + 1'b1;
        end
    end

    assign o_order_valid    = (state != SER_IDLE);
    assign xfer             = o_order_valid && i_order_ready;
    assign o_order_side     = (state == SER_SEND_SELL) ? SIDE_SELL : SIDE_BUY;
    assign o_order_stock_id = stock_p2;
    assign o_order_price    = (state == SER_SEND_SELL) ? sell_p2 :
                              (state == SER_SEND_BUY)  ? buy_p2  : '0;

endmodule

// File: tb/tb_quote_order_gen.sv
// Scoreboard bench for quote_order_gen: stimulus queues expected orders, a
// negedge monitor pops and compares every completed transfer.
module tb_quote_order_gen;

    localparam int DW = 32;
    localparam int NS = 4;
    localparam int FD = 8;
    localparam int SW = 6;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_data_valid = 1'b0;
    logic [IW-1:0] i_stock_id = '0;
    logic [DW-1:0] i_buy_price = '0;
    logic [DW-1:0] i_sell_price = '0;
    logic          i_order_ready = 1'b0;
    logic          o_order_valid;
    logic          o_order_side;
    logic [IW-1:0] o_order_stock_id;
    logic [DW-1:0] o_order_price;
    logic [SW-1:0] o_order_seq;
    logic [15:0]   o_drop_count;

    always #5 clk = ~clk;

    quote_order_gen #(
        .DATA_WIDTH (DW),
        .NUM_STOCKS (NS),
        .FIFO_DEPTH (FD),
        .SEQ_WIDTH  (SW)
    ) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_data_valid     (i_data_valid),
        .i_stock_id       (i_stock_id),
        .i_buy_price      (i_buy_price),
        .i_sell_price     (i_sell_price),
        .o_order_valid    (o_order_valid),
        .i_order_ready    (i_order_ready),
        .o_order_side     (o_order_side),
        .o_order_stock_id (o_order_stock_id),
        .o_order_price    (o_order_price),
        .o_order_seq      (o_order_seq),
        .o_drop_count     (o_drop_count)
    );

    typedef struct {
        logic          side;
        logic [IW-1:0] stock;
        logic [DW-1:0] price;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_xfer = 0;
    int            xfer_mark;
    logic [SW-1:0] exp_seq = '0;
    logic          stalled = 1'b0;
    logic          prev_side;
    logic [IW-1:0] prev_stock;
    logic [DW-1:0] prev_price;
    logic [SW-1:0] prev_seq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_quote(input int stock, input int buy, input int sell, input bit b, input bit s);
        exp_t x;
        x.stock = stock[IW-1:0];
        if (b) begin x.side = 1'b0; x.price = buy;  exp_q.push_back(x); end
        if (s) begin x.side = 1'b1; x.price = sell; exp_q.push_back(x); end
    endtask

    // Called at posedge+1; leaves i_data_valid asserted for possible back-to-back use.
    task automatic drive_quote(input int stock, input int buy, input int sell);
        i_data_valid = 1'b1;
        i_stock_id   = stock[IW-1:0];
        i_buy_price  = buy;
        i_sell_price = sell;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !o_order_valid) break;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({name, "_idle_valid"}, o_order_valid, 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_order_valid) break;
        end
        check({name, "_valid"}, o_order_valid, 1);
    endtask

    always @(negedge clk) begin
        if (i_reset) begin
            exp_seq = '0;
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", o_order_valid, 1);
                check("stall_side",  o_order_side, prev_side);
                check("stall_stock", o_order_stock_id, prev_stock);
                check("stall_price", o_order_price, prev_price);
                check("stall_seq",   o_order_seq, prev_seq);
            end
            if (o_order_valid && i_order_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_order: got side %0d stock %0d price %0d, required no order",
                             o_order_side, o_order_stock_id, o_order_price);
                end else begin
                    e = exp_q.pop_front();
                    check("ord_side",  o_order_side, e.side);
                    check("ord_stock", o_order_stock_id, e.stock);
                    check("ord_price", o_order_price, e.price);
                    check("ord_seq",   o_order_seq, exp_seq);
                end
                exp_seq = exp_seq + 1'b1;
                n_xfer++;
            end
            stalled    = o_order_valid && !i_order_ready;
            prev_side  = o_order_side;
            prev_stock = o_order_stock_id;
            prev_price = o_order_price;
            prev_seq   = o_order_seq;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_valid", o_order_valid, 0);
        check("rst_side",  o_order_side, 0);
        check("rst_stock", o_order_stock_id, 0);
        check("rst_price", o_order_price, 0);
        check("rst_seq",   o_order_seq, 0);
        check("rst_drop",  o_drop_count, 0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_order_ready = 1'b1;
        @(posedge clk); #1;

        // Single quote and its latency
        expect_quote(2, 100, 105, 1, 1);
        drive_quote(2, 100, 105);
        i_data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("lat_n2_valid", o_order_valid, 0);
        @(negedge clk);
        check("lat_n3_valid", o_order_valid, 1);
        @(posedge clk); #1;
        wait_drain("single");

        // Same-stock repeats, back to back
        xfer_mark = n_xfer;
        expect_quote(1, 100, 105, 1, 1);
`ifdef QUOTE_DEDUP_EN
        expect_quote(1, 100, 106, 0, 1);
`else
        expect_quote(1, 100, 106, 1, 1);
        expect_quote(1, 100, 106, 1, 1);
`endif
        drive_quote(1, 100, 105);
        drive_quote(1, 100, 106);
        drive_quote(1, 100, 106);
        i_data_valid = 1'b0;
        wait_drain("dedup");
`ifdef QUOTE_DEDUP_EN
        check("dedup_orders", n_xfer - xfer_mark, 3);
`else
        check("dedup_orders", n_xfer - xfer_mark, 6);
`endif
        check("dedup_drop", o_drop_count, 0);

        // Overflow while stalled: primer occupies the serialiser, burst fills the FIFO
        i_order_ready = 1'b0;
        expect_quote(0, 10, 11, 1, 1);
        drive_quote(0, 10, 11);
        i_data_valid = 1'b0;
        wait_valid("primer");
        @(posedge clk); #1;
        for (int k = 0; k < FD + 3; k++) begin
            if (k < FD) expect_quote(k % NS, 300 + k, 400 + k, 1, 1);
            drive_quote(k % NS, 300 + k, 400 + k);
        end
        i_data_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("ovf_drop", o_drop_count, 3);
        repeat (4) begin @(posedge clk); #1; end
        xfer_mark = n_xfer;
        i_order_ready = 1'b1;
        wait_drain("ovf");
        check("ovf_orders", n_xfer - xfer_mark, 2 + 2 * FD);
        check("ovf_drop_hold", o_drop_count, 3);

        // Reset while a buy order is stalled
        i_order_ready = 1'b0;
        expect_quote(3, 200, 201, 1, 1);
        drive_quote(3, 200, 201);
        i_data_valid = 1'b0;
        wait_valid("prerst");
        #2;
        i_reset = 1'b1;
        #1;
        check("midrst_valid", o_order_valid, 0);
        check("midrst_price", o_order_price, 0);
        check("midrst_seq",   o_order_seq, 0);
        check("midrst_drop",  o_drop_count, 0);
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_order_ready = 1'b1;
        expect_quote(3, 200, 201, 1, 1);
        drive_quote(3, 200, 201);
        i_data_valid = 1'b0;
        wait_drain("postrst");

        // Sequence wrap: 2 orders so far since reset, 72 more passes 2^SW
        for (int i = 0; i < 36; i++) begin
            expect_quote(i % NS, 1000 + i, 2000 + i, 1, 1);
            drive_quote(i % NS, 1000 + i, 2000 + i);
            i_data_valid = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
        end
        wait_drain("wrap");
        check("wrap_seq_final", o_order_seq, 10);
        check("wrap_drop", o_drop_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
